// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receive/transmit path:
//                parity selection, receiver state encoding and the 2-of-3
//                majority voter used for oversampled bit decisions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity selection, matches the PARITY_TYPE parameter encoding
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  // Receiver FSM states, explicitly encoded in 3 bits
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Oversample tick generator. Counts 0..CLK_DIV-1 while enabled
//                and asserts tick for one clk on the terminal count. Held at 0
//                while disabled so every enable starts a full period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int              C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(CLK_DIV - 1);

  logic [C_CNT_W-1:0] r_cnt;

  // Divider counter: restarts from 0 whenever the enable drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_CNT_W'(1);
    end
  end

  assign tick = en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : Oversampling UART receiver. 2-flop input synchroniser,
//                3-sample majority vote per bit, start-bit glitch rejection,
//                parity and stop checks, valid/ready output with overrun flag.
//                Optional line-break detection enabled by defining the macro
//                UART_RX_BREAK_DET_EN; without it break_det is tied low and a
//                break frame is delivered as data 0 with frame_err set.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 27,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic                 break_det
);

  localparam int C_OS_W = $clog2(OVERSAMPLE);
  localparam int C_BC_W = $clog2(DATA_BITS + 1);

  // Sample points bracket the bit centre; the vote uses the third sample live
  localparam logic [C_OS_W-1:0] C_SMP0 = C_OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [C_OS_W-1:0] C_SMP1 = C_OS_W'(OVERSAMPLE / 2);
  localparam logic [C_OS_W-1:0] C_VOTE = C_OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [C_OS_W-1:0] C_WRAP = C_OS_W'(OVERSAMPLE - 1);

  localparam logic [C_BC_W-1:0] C_LAST_BIT  = C_BC_W'(DATA_BITS - 1);
  localparam logic              C_LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam bit C_HAS_PAR = (PARITY_TYPE == int'(PARITY_EVEN)) ||
                             (PARITY_TYPE == int'(PARITY_ODD));

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                 r_rx_meta;
  logic                 r_rx_sync;

  rx_state_e            r_state;
  rx_state_e            w_next;

  logic                 w_baud_en;
  logic                 w_tick;
  logic                 w_busy;

  logic [C_OS_W-1:0]    r_os_cnt;
  logic                 r_smp0;
  logic                 r_smp1;
  logic                 w_vote_pt;
  logic                 w_wrap;
  logic                 w_bit;

  logic [C_BC_W-1:0]    r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;

  logic                 w_shift_en;
  logic                 w_par_cap;
  logic                 w_stop_vote;
  logic                 w_final;
  logic                 w_par_err;
  logic                 w_frame_err;

  logic                 r_cmp_vld;
  logic [DATA_BITS-1:0] r_cmp_data;
  logic                 r_cmp_perr;
  logic                 r_cmp_ferr;

  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  // --------------------------------------------------------------------------
  // Input synchroniser (idle-high line, so flops reset to 1)
  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous rx pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Oversample tick
  // --------------------------------------------------------------------------
  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_baud_en),
    .tick  (w_tick)
  );

  // Position within the current bit; parked at 0 when not framing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt <= '0;
    end else if ((r_state == IDLE) || (r_state == BRK)) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= (r_os_cnt == C_WRAP) ? '0 : r_os_cnt + C_OS_W'(1);
    end
  end

  // Capture the two early samples; the third is taken live at the vote point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp0 <= 1'b0;
      r_smp1 <= 1'b0;
    end else if (w_tick) begin
      if (r_os_cnt == C_SMP0) r_smp0 <= r_rx_sync;
      if (r_os_cnt == C_SMP1) r_smp1 <= r_rx_sync;
    end
  end

  assign w_vote_pt = w_tick && (r_os_cnt == C_VOTE);
  assign w_wrap    = w_tick && (r_os_cnt == C_WRAP);
  assign w_bit     = maj3(r_smp0, r_smp1, r_rx_sync);

  // --------------------------------------------------------------------------
  // Break detection support
  // --------------------------------------------------------------------------
`ifdef UART_RX_BREAK_DET_EN
  logic r_all_zero;
  logic w_is_break;
  logic r_cmp_brk;
  logic r_break_det;

  // Tracks whether every vote since the start bit has been 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_zero <= 1'b0;
    end else if (r_state == START) begin
      r_all_zero <= 1'b1;
    end else if (w_vote_pt && w_bit) begin
      r_all_zero <= 1'b0;
    end
  end

  assign w_is_break = r_all_zero && !w_bit;

  // Break pulse is aligned with where valid would have risen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_brk   <= 1'b0;
      r_break_det <= 1'b0;
    end else begin
      r_cmp_brk   <= w_final && w_is_break;
      r_break_det <= r_cmp_brk;
    end
  end

  assign break_det = r_break_det;
`else
  assign break_det = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!r_rx_sync) w_next = START;
      end
      START: begin
        // A high vote means the falling edge was a glitch
        if (w_vote_pt && w_bit) w_next = IDLE;
        else if (w_wrap)        w_next = DATA;
      end
      DATA: begin
        if (w_wrap && (r_bit_cnt == C_LAST_BIT)) w_next = C_HAS_PAR ? PARITY : STOP;
      end
      PARITY: begin
        if (w_wrap) w_next = STOP;
      end
      STOP: begin
        // The final stop bit ends at its vote point so the next start edge
        // can be caught without losing half a bit
        if (w_final) begin
`ifdef UART_RX_BREAK_DET_EN
          w_next = w_is_break ? BRK : IDLE;
`else
          w_next = IDLE;
`endif
        end
      end
      BRK: begin
        if (r_rx_sync) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_baud_en   = (r_state != IDLE) && (r_state != BRK);
    w_shift_en  = (r_state == DATA)   && w_vote_pt;
    w_par_cap   = (r_state == PARITY) && w_vote_pt;
    w_stop_vote = (r_state == STOP)   && w_vote_pt;
    w_final     = w_stop_vote && (r_stop_cnt == C_LAST_STOP);
  end

  assign busy = w_busy;

  // --------------------------------------------------------------------------
  // Frame datapath
  // --------------------------------------------------------------------------
  // Shift register, bit/stop counters and accumulated stop error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_stop_err <= 1'b0;
      end
      if (w_shift_en)                      r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
      if ((r_state == DATA) && w_wrap)     r_bit_cnt  <= r_bit_cnt + C_BC_W'(1);
      if (w_par_cap)                       r_par_bit  <= w_bit;
      if (w_stop_vote && !w_bit)           r_stop_err <= 1'b1;
      if ((r_state == STOP) && w_wrap)     r_stop_cnt <= 1'b1;
    end
  end

  if (PARITY_TYPE == int'(PARITY_EVEN)) begin : g_par_even
    assign w_par_err = ^{r_shift, r_par_bit};
  end else if (PARITY_TYPE == int'(PARITY_ODD)) begin : g_par_odd
    assign w_par_err = ~(^{r_shift, r_par_bit});
  end else begin : g_par_none
    assign w_par_err = 1'b0;
  end

  // Include the stop bit being voted right now
  assign w_frame_err = r_stop_err | ~w_bit;

  // Completion stage: frame result registered at the final vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_data <= '0;
      r_cmp_perr <= 1'b0;
      r_cmp_ferr <= 1'b0;
    end else begin
`ifdef UART_RX_BREAK_DET_EN
      r_cmp_vld <= w_final && !w_is_break;
`else
      r_cmp_vld <= w_final;
`endif
      if (w_final) begin
        r_cmp_data <= r_shift;
        r_cmp_perr <= w_par_err;
        r_cmp_ferr <= w_frame_err;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register with valid/ready handshake and overrun
  // --------------------------------------------------------------------------
  // A completion always wins; overrun only if the old word was not taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_cmp_vld) begin
      r_data_out   <= r_cmp_data;
      r_parity_err <= r_cmp_perr;
      r_frame_err  <= r_cmp_ferr;
      r_valid      <= 1'b1;
      if (r_valid && !out_ready)     r_overrun <= 1'b1;
      else if (r_valid && out_ready) r_overrun <= 1'b0;
    end else if (r_valid && out_ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire
